// File: rtl/dma_io_peripheral.sv
// dma_io_peripheral: peripheral-side responder for an 8237A-style DMA channel.
// Holds an outgoing FIFO (drained by IOR_N strobes) and an incoming FIFO
// (filled by IOW_N strobes), raises DREQ while service is needed and tracks
// terminal count (EOP_N) and strobe protocol violations.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | no request; mode latched; waits for enable and FIFO need
// S_REQ    | DREQ high, waiting for DACK
// S_ACKED  | DACK seen, waiting for the strobe on the latched path
// S_STROBE | strobe low; word completes on its rising edge
module dma_io_peripheral #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             DACK,
    input  logic             IOR_N,
    input  logic             IOW_N,
    input  logic             EOP_N,
    input  logic [WIDTH-1:0] DB_IN,
    output logic [WIDTH-1:0] DB_OUT,
    output logic             DB_OE,
    output logic             DREQ,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    input  logic             rx_ready,
    output logic             tc_seen,
    output logic             proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [1:0] MODE_D2M = 2'b01;
    localparam logic [1:0] MODE_M2D = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACKED, S_STROBE} state_t;

    state_t           r_state;
    logic [1:0]       r_mode_q;
    logic             r_dreq;
    logic             r_db_oe;
    logic [WIDTH-1:0] r_db_out;
    logic [WIDTH-1:0] r_wr_data;
    logic             r_eop_pend;
    logic             r_tc_seen;
    logic             r_proto_err;

    logic [WIDTH-1:0] r_tx_mem [DEPTH];
    logic [AW-1:0]    r_tx_wr;
    logic [AW-1:0]    r_tx_rd;
    logic [AW:0]      r_tx_cnt;
    logic [WIDTH-1:0] r_rx_mem [DEPTH];
    logic [AW-1:0]    r_rx_wr;
    logic [AW-1:0]    r_rx_rd;
    logic [AW:0]      r_rx_cnt;

    logic             w_proto;
    logic             w_tx_push;
    logic             w_tx_pop;
    logic             w_rx_push;
    logic             w_rx_pop;
    logic [AW:0]      w_tx_cnt_next;
    logic [AW:0]      w_rx_cnt_next;
    logic             w_more;
    logic             w_eop_now;

    // FIFO handshakes and DMA-side transfer strobes
    always_comb begin
        w_proto   = DACK && !IOR_N && !IOW_N;
        w_tx_push = tx_valid && (r_tx_cnt != FULL);
        w_rx_pop  = rx_ready && (r_rx_cnt != '0);
        // a word completes only on the strobe rise while still acknowledged
        w_tx_pop  = (r_state == S_STROBE) && (r_mode_q == MODE_D2M) && DACK && IOR_N && !w_proto;
        w_rx_push = (r_state == S_STROBE) && (r_mode_q == MODE_M2D) && DACK && IOW_N && !w_proto;
        w_tx_cnt_next = r_tx_cnt + {{AW{1'b0}}, w_tx_push} - {{AW{1'b0}}, w_tx_pop};
        w_rx_cnt_next = r_rx_cnt + {{AW{1'b0}}, w_rx_push} - {{AW{1'b0}}, w_rx_pop};
        w_more    = (r_mode_q == MODE_D2M) ? (w_tx_cnt_next != '0) : (w_rx_cnt_next != FULL);
        w_eop_now = r_eop_pend || !EOP_N;
    end

    // FIFO storage; contents need no reset because pointers and counts do
    always_ff @(posedge CLK) begin
        if (w_tx_push) r_tx_mem[r_tx_wr] <= tx_data;
        if (w_rx_push) r_rx_mem[r_rx_wr] <= r_wr_data;
    end

    // FIFO pointers and occupancy counters
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_tx_cnt <= '0;
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
            if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
            r_tx_cnt <= w_tx_cnt_next;
            r_rx_cnt <= w_rx_cnt_next;
        end
    end

    // Sticky protocol-error flag: both strobes low while acknowledged
    always_ff @(posedge CLK) begin
        if (RESET)        r_proto_err <= 1'b0;
        else if (w_proto) r_proto_err <= 1'b1;
    end

    // Request/strobe sequencer with registered DREQ, DB_OE and DB_OUT
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_mode_q   <= 2'b00;
            r_dreq     <= 1'b0;
            r_db_oe    <= 1'b0;
            r_db_out   <= '0;
            r_wr_data  <= '0;
            r_eop_pend <= 1'b0;
            r_tc_seen  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_dreq     <= 1'b0;
                    r_db_oe    <= 1'b0;
                    r_eop_pend <= 1'b0;
                    r_mode_q   <= mode;
                    if (!enable) r_tc_seen <= 1'b0;
                    if (enable && !r_tc_seen &&
                        (((mode == MODE_D2M) && (r_tx_cnt != '0)) ||
                         ((mode == MODE_M2D) && (r_rx_cnt != FULL)))) begin
                        r_state <= S_REQ;
                        r_dreq  <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (DACK) begin
                        r_state <= S_ACKED;
                    end else if (!enable) begin
                        r_state <= S_IDLE;
                        r_dreq  <= 1'b0;
                    end
                end
                S_ACKED: begin
                    if (!DACK) begin
                        r_state <= S_IDLE;
                        r_dreq  <= 1'b0;
                    end else begin
                        if (!EOP_N) r_eop_pend <= 1'b1;
                        // a colliding strobe pair never starts a word
                        if (!w_proto) begin
                            if ((r_mode_q == MODE_D2M) && !IOR_N) begin
                                r_state  <= S_STROBE;
                                r_db_oe  <= 1'b1;
                                r_db_out <= r_tx_mem[r_tx_rd];
                            end else if ((r_mode_q == MODE_M2D) && !IOW_N) begin
                                r_state   <= S_STROBE;
                                r_wr_data <= DB_IN;
                            end
                        end
                    end
                end
                S_STROBE: begin
                    if (!DACK) begin
                        r_state <= S_IDLE;
                        r_dreq  <= 1'b0;
                        r_db_oe <= 1'b0;
                    end else begin
                        if (!EOP_N) r_eop_pend <= 1'b1;
                        if ((r_mode_q == MODE_M2D) && !IOW_N) r_wr_data <= DB_IN;
                        if (w_tx_pop || w_rx_push) begin
                            r_db_oe <= 1'b0;
                            if (w_eop_now) begin
                                r_tc_seen  <= 1'b1;
                                r_eop_pend <= 1'b0;
                                r_state    <= S_IDLE;
                                r_dreq     <= 1'b0;
                            end else if (w_more) begin
                                r_state <= S_ACKED;
                            end else begin
                                r_state <= S_IDLE;
                                r_dreq  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_dreq  <= 1'b0;
                    r_db_oe <= 1'b0;
                end
            endcase
        end
    end

    assign DREQ      = r_dreq;
    assign DB_OE     = r_db_oe;
    assign DB_OUT    = r_db_out;
    assign tc_seen   = r_tc_seen;
    assign proto_err = r_proto_err;
    assign tx_ready  = (r_tx_cnt != FULL);
    assign rx_valid  = (r_rx_cnt != '0);
    assign rx_data   = r_rx_mem[r_rx_rd];

endmodule

// File: tb/tb_dma_io_peripheral.sv
// Bench for dma_io_peripheral: plays the DMA controller and the local side,
// with queues holding the words expected on DB_OUT and rx_data.
module tb_dma_io_peripheral;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       DACK = 1'b0;
    logic       IOR_N = 1'b1;
    logic       IOW_N = 1'b1;
    logic       EOP_N = 1'b1;
    logic [7:0] DB_IN = 8'h00;
    logic [7:0] DB_OUT;
    logic       DB_OE;
    logic       DREQ;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready = 1'b0;
    logic       tc_seen;
    logic       proto_err;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    dma_io_peripheral #(.DEPTH(8), .WIDTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .enable(enable), .mode(mode), .DACK(DACK),
        .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N), .DB_IN(DB_IN),
        .DB_OUT(DB_OUT), .DB_OE(DB_OE), .DREQ(DREQ),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tc_seen(tc_seen), .proto_err(proto_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] d);
        logic accepted;
        tx_valid = 1'b1;
        tx_data  = d;
        accepted = tx_ready;
        step();
        if (accepted) tx_q.push_back(d);
        tx_valid = 1'b0;
    endtask

    task automatic wait_dreq(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (DREQ === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic ior_pulse(output logic oe_during, output logic [7:0] dout, output logic oe_after);
        IOR_N = 1'b0;
        step();
        oe_during = DB_OE;
        dout      = DB_OUT;
        IOR_N = 1'b1;
        step();
        oe_after = DB_OE;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
        n_checks++; if (DREQ !== 1'b0) begin n_fail++; $display("FAIL reset_dreq: got %b want 0", DREQ); end
        n_checks++; if (DB_OE !== 1'b0) begin n_fail++; $display("FAIL reset_db_oe: got %b want 0", DB_OE); end
        n_checks++; if (DB_OUT !== 8'h00) begin n_fail++; $display("FAIL reset_db_out: got %h want 00", DB_OUT); end
        n_checks++; if (tc_seen !== 1'b0) begin n_fail++; $display("FAIL reset_tc_seen: got %b want 0", tc_seen); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    endtask

    task automatic test_dev_to_mem();
        bit ok;
        logic oe_d, oe_a;
        logic [7:0] dout, exp;
        push_tx(8'h11);
        push_tx(8'h22);
        push_tx(8'h33);
        mode = 2'b01;
        enable = 1'b1;
        wait_dreq(5, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL d2m_dreq_raise: got DREQ=%b want 1 within 5 cycles", DREQ); end
        DACK = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            ior_pulse(oe_d, dout, oe_a);
            exp = tx_q.pop_front();
            n_checks++; if (oe_d !== 1'b1) begin n_fail++; $display("FAIL d2m_oe_during[%0d]: got %b want 1", i, oe_d); end
            n_checks++; if (dout !== exp) begin n_fail++; $display("FAIL d2m_db_out[%0d]: got %h want %h", i, dout, exp); end
            n_checks++; if (oe_a !== 1'b0) begin n_fail++; $display("FAIL d2m_oe_after[%0d]: got %b want 0", i, oe_a); end
            n_checks++; if (DREQ !== (i < 2)) begin n_fail++; $display("FAIL d2m_dreq_after[%0d]: got %b want %b", i, DREQ, (i < 2)); end
        end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL d2m_tx_ready: got %b want 1", tx_ready); end
        DACK = 1'b0;
        enable = 1'b0;
        step();
    endtask

    task automatic test_mem_to_dev();
        bit ok;
        logic [7:0] exp;
        mode = 2'b10;
        enable = 1'b1;
        wait_dreq(5, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL m2d_dreq_raise: got DREQ=%b want 1 within 5 cycles", DREQ); end
        DACK = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            IOW_N = 1'b0;
            DB_IN = 8'hA0 + 8'(i);
            step();
            IOW_N = 1'b1;
            DB_IN = 8'hFF;
            step();
            rx_q.push_back(8'hA0 + 8'(i));
            n_checks++; if (DREQ !== (i < 7)) begin n_fail++; $display("FAIL m2d_dreq_after[%0d]: got %b want %b", i, DREQ, (i < 7)); end
        end
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL m2d_rx_valid: got %b want 1", rx_valid); end
        DACK = 1'b0;
        step();
        n_checks++; if (DREQ !== 1'b0) begin n_fail++; $display("FAIL m2d_full_no_dreq: got %b want 0", DREQ); end
        exp = rx_q.pop_front();
        rx_ready = 1'b1;
        n_checks++; if (rx_data !== exp) begin n_fail++; $display("FAIL m2d_rx_data_first: got %h want %h", rx_data, exp); end
        step();
        rx_ready = 1'b0;
        wait_dreq(2, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL m2d_dreq_reraise: got DREQ=%b want 1 within 2 cycles", DREQ); end
        enable = 1'b0;
        step();
        while (rx_q.size() > 0) begin
            exp = rx_q.pop_front();
            rx_ready = 1'b1;
            n_checks++; if (rx_data !== exp || rx_valid !== 1'b1) begin n_fail++; $display("FAIL m2d_rx_data: got %h valid %b want %h", rx_data, rx_valid, exp); end
            step();
        end
        rx_ready = 1'b0;
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL m2d_rx_drained: got %b want 0", rx_valid); end
    endtask

    task automatic test_eop();
        bit ok;
        bit stayed_low;
        logic oe_d, oe_a;
        logic [7:0] dout, exp;
        mode = 2'b01;
        for (int i = 0; i < 4; i++) push_tx(8'h40 + 8'(i));
        enable = 1'b1;
        wait_dreq(5, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL eop_dreq_raise: got DREQ=%b want 1", DREQ); end
        DACK = 1'b1;
        step();
        ior_pulse(oe_d, dout, oe_a);
        exp = tx_q.pop_front();
        n_checks++; if (dout !== exp) begin n_fail++; $display("FAIL eop_word1: got %h want %h", dout, exp); end
        IOR_N = 1'b0;
        EOP_N = 1'b0;
        step();
        exp = tx_q.pop_front();
        n_checks++; if (DB_OUT !== exp) begin n_fail++; $display("FAIL eop_word2: got %h want %h", DB_OUT, exp); end
        IOR_N = 1'b1;
        EOP_N = 1'b1;
        step();
        n_checks++; if (tc_seen !== 1'b1) begin n_fail++; $display("FAIL eop_tc_seen: got %b want 1", tc_seen); end
        n_checks++; if (DREQ !== 1'b0) begin n_fail++; $display("FAIL eop_dreq_drop: got %b want 0", DREQ); end
        DACK = 1'b0;
        stayed_low = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (DREQ !== 1'b0) stayed_low = 1'b0;
        end
        n_checks++; if (!stayed_low) begin n_fail++; $display("FAIL eop_dreq_held_low: got DREQ high want 0 with tc_seen set"); end
        enable = 1'b0;
        step();
        n_checks++; if (tc_seen !== 1'b0) begin n_fail++; $display("FAIL eop_tc_clear: got %b want 0", tc_seen); end
        enable = 1'b1;
        wait_dreq(3, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL eop_dreq_resume: got DREQ=%b want 1", DREQ); end
        DACK = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            ior_pulse(oe_d, dout, oe_a);
            exp = tx_q.pop_front();
            n_checks++; if (dout !== exp) begin n_fail++; $display("FAIL eop_remaining[%0d]: got %h want %h", i, dout, exp); end
        end
        n_checks++; if (DREQ !== 1'b0) begin n_fail++; $display("FAIL eop_final_dreq: got %b want 0", DREQ); end
        DACK = 1'b0;
        enable = 1'b0;
        step();
    endtask

    task automatic test_dack_abort();
        bit ok;
        logic oe_d, oe_a;
        logic [7:0] dout, exp;
        mode = 2'b01;
        push_tx(8'h55);
        push_tx(8'h66);
        enable = 1'b1;
        wait_dreq(5, ok);
        DACK = 1'b1;
        step();
        IOR_N = 1'b0;
        step();
        n_checks++; if (DB_OE !== 1'b1) begin n_fail++; $display("FAIL abort_oe_on: got %b want 1", DB_OE); end
        DACK = 1'b0;
        step();
        IOR_N = 1'b1;
        n_checks++; if (DB_OE !== 1'b0 || DREQ !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got oe=%b dreq=%b want 0/0", DB_OE, DREQ); end
        wait_dreq(5, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_dreq_again: got DREQ=%b want 1", DREQ); end
        DACK = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            ior_pulse(oe_d, dout, oe_a);
            exp = tx_q.pop_front();
            n_checks++; if (dout !== exp) begin n_fail++; $display("FAIL abort_word[%0d]: got %h want %h", i, dout, exp); end
        end
        n_checks++; if (DREQ !== 1'b0) begin n_fail++; $display("FAIL abort_final_dreq: got %b want 0", DREQ); end
        DACK = 1'b0;
        enable = 1'b0;
        step();
    endtask

    task automatic test_proto_err();
        bit ok;
        logic oe_d, oe_a;
        logic [7:0] dout, exp;
        mode = 2'b01;
        push_tx(8'h77);
        enable = 1'b1;
        wait_dreq(5, ok);
        DACK = 1'b1;
        step();
        IOR_N = 1'b0;
        IOW_N = 1'b0;
        step();
        IOR_N = 1'b1;
        IOW_N = 1'b1;
        step();
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_err_set: got %b want 1", proto_err); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL proto_no_push: got rx_valid %b want 0", rx_valid); end
        n_checks++; if (DREQ !== 1'b1) begin n_fail++; $display("FAIL proto_still_req: got %b want 1", DREQ); end
        ior_pulse(oe_d, dout, oe_a);
        exp = tx_q.pop_front();
        n_checks++; if (dout !== exp || oe_d !== 1'b1) begin n_fail++; $display("FAIL proto_word_kept: got %h oe %b want %h oe 1", dout, oe_d, exp); end
        n_checks++; if (DREQ !== 1'b0) begin n_fail++; $display("FAIL proto_final_dreq: got %b want 0", DREQ); end
        DACK = 1'b0;
        enable = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        bit ok;
        mode = 2'b01;
        for (int i = 0; i < 9; i++) push_tx(8'h80 + 8'(i));
        n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL full_tx_ready: got %b want 0", tx_ready); end
        n_checks++; if (tx_q.size() != 8) begin n_fail++; $display("FAIL full_accept_count: got %0d want 8", tx_q.size()); end
        enable = 1'b1;
        wait_dreq(5, ok);
        DACK = 1'b1;
        step();
        IOR_N = 1'b0;
        step();
        n_checks++; if (DB_OE !== 1'b1 || DB_OUT !== 8'h80) begin n_fail++; $display("FAIL mid_strobe: got oe %b out %h want 1 80", DB_OE, DB_OUT); end
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        IOR_N = 1'b1;
        DACK = 1'b0;
        tx_q.delete();
        n_checks++; if (DREQ !== 1'b0 || DB_OE !== 1'b0) begin n_fail++; $display("FAIL mid_reset_outs: got dreq %b oe %b want 0 0", DREQ, DB_OE); end
        n_checks++; if (tx_ready !== 1'b1 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_fifo: got tx_ready %b rx_valid %b want 1 0", tx_ready, rx_valid); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL mid_reset_proto: got %b want 0", proto_err); end
        step();
        step();
        n_checks++; if (DREQ !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flushed: got DREQ %b want 0", DREQ); end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dev_to_mem();
        test_mem_to_dev();
        test_eop();
        test_dack_abort();
        test_proto_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
